// File: rtl/writeback_arbiter_if.sv
// Writeback-stage bus: memaccess and execute write requests, read ports and
// the writeback_out signals (VSR1, VSR2, psr, enable_writeback).
interface writeback_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 3
);
    logic              mem_valid;
    logic [AW-1:0]     mem_dr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              exe_valid;
    logic [AW-1:0]     exe_dr;
    logic [DATA_W-1:0] exe_data;
    logic              exe_set_cc;
    logic              exe_ready;
    logic [AW-1:0]     sr1;
    logic [AW-1:0]     sr2;
    logic [DATA_W-1:0] VSR1;
    logic [DATA_W-1:0] VSR2;
    logic [2:0]        psr;
    logic              enable_writeback;

    modport master (
        output mem_valid, mem_dr, mem_data, exe_valid, exe_dr, exe_data, exe_set_cc, sr1, sr2,
        input  mem_ready, exe_ready, VSR1, VSR2, psr, enable_writeback
    );

    modport slave (
        input  mem_valid, mem_dr, mem_data, exe_valid, exe_dr, exe_data, exe_set_cc, sr1, sr2,
        output mem_ready, exe_ready, VSR1, VSR2, psr, enable_writeback
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback stage: owns the GPR file and PSR, arbitrates the single RF write
// port between memaccess and execute with a starvation guard for execute.
module writeback_arbiter #(
    parameter int DATA_W       = 16,
    parameter int NREG         = 8,
    parameter int STARVE_LIMIT = 3
) (
    input logic               clock,
    input logic               reset,
    writeback_arbiter_if.slave bus
);
    localparam int AW    = $clog2(NREG);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {
        PRIO_MEM = 1'b0,
        PRIO_EXE = 1'b1
    } state_t;

    function automatic logic [2:0] cc_of(input logic [DATA_W-1:0] d);
        if (d[DATA_W-1]) begin
            return 3'b100;
        end else if (d == {DATA_W{1'b0}}) begin
            return 3'b010;
        end else begin
            return 3'b001;
        end
    endfunction

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [DATA_W-1:0] rf_r [NREG];
    logic [2:0]        psr_r;
    logic              ewb_r;
    logic              grant_mem_s, grant_exe_s;
    logic              wr_en_s, cc_upd_s;
    logic [AW-1:0]     wr_dr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [DATA_W-1:0] vsr1_s, vsr2_s;

    // Arbitration: grants, next priority state and starvation counter
    always_comb begin
        grant_mem_s = 1'b0;
        grant_exe_s = 1'b0;
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (reset) begin
            state_nxt_s = PRIO_MEM;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                PRIO_MEM: begin
                    if (bus.mem_valid) begin
                        grant_mem_s = 1'b1;
                        if (bus.exe_valid) begin
                            // Execute was denied: escalate once the limit is hit
                            if (cnt_r == CNT_W'(STARVE_LIMIT - 1)) begin
                                state_nxt_s = PRIO_EXE;
                                cnt_nxt_s   = {CNT_W{1'b0}};
                            end else begin
                                cnt_nxt_s = cnt_r + CNT_W'(1);
                            end
                        end else begin
                            cnt_nxt_s = cnt_r;
                        end
                    end else if (bus.exe_valid) begin
                        grant_exe_s = 1'b1;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                PRIO_EXE: begin
                    if (bus.exe_valid) begin
                        grant_exe_s = 1'b1;
                        state_nxt_s = PRIO_MEM;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else if (bus.mem_valid) begin
                        grant_mem_s = 1'b1;
                        state_nxt_s = PRIO_MEM;
                    end else begin
                        state_nxt_s = PRIO_EXE;
                    end
                end
                default: begin
                    state_nxt_s = PRIO_MEM;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Write-port mux and combinational read ports with same-cycle bypass
    always_comb begin
        wr_en_s   = grant_mem_s | grant_exe_s;
        cc_upd_s  = grant_mem_s | (grant_exe_s & bus.exe_set_cc);
        wr_dr_s   = bus.exe_dr;
        wr_data_s = bus.exe_data;
        if (grant_mem_s) begin
            wr_dr_s   = bus.mem_dr;
            wr_data_s = bus.mem_data;
        end else begin
            wr_dr_s   = bus.exe_dr;
            wr_data_s = bus.exe_data;
        end
        vsr1_s = rf_r[bus.sr1];
        vsr2_s = rf_r[bus.sr2];
        if (wr_en_s && (wr_dr_s == bus.sr1)) begin
            vsr1_s = wr_data_s;
        end else begin
            vsr1_s = rf_r[bus.sr1];
        end
        if (wr_en_s && (wr_dr_s == bus.sr2)) begin
            vsr2_s = wr_data_s;
        end else begin
            vsr2_s = rf_r[bus.sr2];
        end
    end

    // State, register file, PSR and commit pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= PRIO_MEM;
            cnt_r   <= {CNT_W{1'b0}};
            psr_r   <= 3'b010;
            ewb_r   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ewb_r   <= wr_en_s;
            if (wr_en_s) begin
                rf_r[wr_dr_s] <= wr_data_s;
            end
            if (cc_upd_s) begin
                psr_r <= cc_of(wr_data_s);
            end
        end
    end

    assign bus.mem_ready        = grant_mem_s;
    assign bus.exe_ready        = grant_exe_s;
    assign bus.VSR1             = vsr1_s;
    assign bus.VSR2             = vsr2_s;
    assign bus.psr              = psr_r;
    assign bus.enable_writeback = ewb_r;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed testbench for writeback_arbiter with immediate-assertion checks.
module tb_writeback_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    writeback_arbiter_if #(.DATA_W(16), .AW(3)) bus ();

    writeback_arbiter #(.DATA_W(16), .NREG(8), .STARVE_LIMIT(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] grant_mem_exp;
        grant_mem_exp = 8'b0111_0111;

        bus.mem_valid = 1'b1; bus.mem_dr = 3'd0; bus.mem_data = 16'h0000;
        bus.exe_valid = 1'b1; bus.exe_dr = 3'd0; bus.exe_data = 16'h0000;
        bus.exe_set_cc = 1'b0; bus.sr1 = 3'd0; bus.sr2 = 3'd0;

        // 1: reset
        tick();
        chk("rst_mem_ready", {15'd0, bus.mem_ready}, 16'd0);
        chk("rst_exe_ready", {15'd0, bus.exe_ready}, 16'd0);
        tick();
        bus.mem_valid = 1'b0; bus.exe_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_psr", {13'd0, bus.psr}, 16'h0002);
        chk("rst_ewb", {15'd0, bus.enable_writeback}, 16'd0);
        for (int i = 0; i < 8; i++) begin
            bus.sr1 = 3'(i); bus.sr2 = 3'(7 - i);
            #1;
            chk("rst_vsr1", bus.VSR1, 16'h0000);
            chk("rst_vsr2", bus.VSR2, 16'h0000);
        end

        // 2: execute write with cc update
        bus.exe_valid = 1'b1; bus.exe_dr = 3'd3; bus.exe_data = 16'h8001; bus.exe_set_cc = 1'b1;
        #1;
        chk("t2_exe_ready", {15'd0, bus.exe_ready}, 16'd1);
        chk("t2_mem_ready", {15'd0, bus.mem_ready}, 16'd0);
        tick();
        bus.exe_valid = 1'b0; bus.sr1 = 3'd3;
        #1;
        chk("t2_ewb", {15'd0, bus.enable_writeback}, 16'd1);
        chk("t2_psr", {13'd0, bus.psr}, 16'h0004);
        chk("t2_vsr1", bus.VSR1, 16'h8001);
        tick();
        chk("t2_ewb_drop", {15'd0, bus.enable_writeback}, 16'd0);

        // 3: contention with starvation guard -> M,M,M,E,M,M,M,E
        bus.exe_set_cc = 1'b0;
        bus.mem_dr = 3'd1; bus.exe_dr = 3'd4;
        bus.mem_valid = 1'b1; bus.exe_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.mem_data = 16'h0010 + 16'(i);
            bus.exe_data = 16'h0040 + 16'(i);
            #1;
            chk("t3_mem_ready", {15'd0, bus.mem_ready}, {15'd0, grant_mem_exp[i]});
            chk("t3_exe_ready", {15'd0, bus.exe_ready}, {15'd0, ~grant_mem_exp[i]});
            chk("t3_one_hot", {15'd0, bus.mem_ready & bus.exe_ready}, 16'd0);
            tick();
            chk("t3_ewb", {15'd0, bus.enable_writeback}, 16'd1);
        end
        bus.mem_valid = 1'b0; bus.exe_valid = 1'b0;
        bus.sr1 = 3'd1; bus.sr2 = 3'd4;
        #1;
        chk("t3_rf1", bus.VSR1, 16'h0016);
        chk("t3_rf4", bus.VSR2, 16'h0047);

        // 4: dual bypass
        bus.sr1 = 3'd5; bus.sr2 = 3'd5;
        bus.exe_valid = 1'b1; bus.exe_dr = 3'd5; bus.exe_data = 16'h1234; bus.exe_set_cc = 1'b1;
        #1;
        chk("t4_vsr1_byp", bus.VSR1, 16'h1234);
        chk("t4_vsr2_byp", bus.VSR2, 16'h1234);
        tick();
        bus.exe_valid = 1'b0;
        #1;
        chk("t4_psr", {13'd0, bus.psr}, 16'h0001);
        tick();
        chk("idle_ewb", {15'd0, bus.enable_writeback}, 16'd0);
        chk("idle_psr", {13'd0, bus.psr}, 16'h0001);
        chk("idle_rf5", bus.VSR1, 16'h1234);

        // 5: mem zero sets Z, exe without set_cc leaves psr
        bus.mem_valid = 1'b1; bus.mem_dr = 3'd6; bus.mem_data = 16'h0000;
        tick();
        bus.mem_valid = 1'b0;
        #1;
        chk("t5_psr_z", {13'd0, bus.psr}, 16'h0002);
        bus.exe_valid = 1'b1; bus.exe_dr = 3'd7; bus.exe_data = 16'h0007; bus.exe_set_cc = 1'b0;
        tick();
        bus.exe_valid = 1'b0; bus.sr1 = 3'd7;
        #1;
        chk("t5_psr_hold", {13'd0, bus.psr}, 16'h0002);
        chk("t5_rf7", bus.VSR1, 16'h0007);

        // 6: reset during a mem grant discards the write
        bus.mem_valid = 1'b1; bus.mem_dr = 3'd2; bus.mem_data = 16'hFFFF;
        reset = 1'b1;
        #1;
        chk("t6_mem_ready", {15'd0, bus.mem_ready}, 16'd0);
        tick();
        reset = 1'b0; bus.mem_valid = 1'b0; bus.sr1 = 3'd2;
        #1;
        chk("t6_rf2", bus.VSR1, 16'h0000);
        chk("t6_psr", {13'd0, bus.psr}, 16'h0002);
        chk("t6_ewb", {15'd0, bus.enable_writeback}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
